// File: rtl/core_db_pkg.sv
// Shared types and width helpers for the SECDED data-bucket core.
package core_db_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CORR   = 2'b01,
    ERR_UNCORR = 2'b10
  } err_t;

  function automatic int code_w(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int data_w(input int r);
    return code_w(r) - r;
  endfunction

  // 0-based code index of the k-th data bit (k-th non-power-of-two position).
  function automatic int data_pos(input int r, input int k);
    int pos;
    int seen;
    pos  = 0;
    seen = 0;
    for (int j = 0; j < code_w(r); j++) begin
      if (((j + 1) & j) != 0) begin
        if (seen == k) pos = j;
        seen++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_dec.sv
// Combinational Hamming SECDED decoder: syndrome + overall parity, single-bit fix, data strip.
module secded_dec
  import core_db_pkg::*;
#(
  parameter int R = 3
) (
  input  logic [code_w(R)-1:0] code,
  input  logic                 p0,
  output logic [data_w(R)-1:0] data,
  output err_t                 err
);

  localparam int N = code_w(R);
  localparam int K = data_w(R);

  logic [R-1:0] syn;
  logic         par;
  logic [N-1:0] fixed;

  always_comb begin
    syn = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < N; j++)
        if ((((j + 1) >> i) & 1) != 0) syn[i] = syn[i] ^ code[j];
    par   = ^{p0, code};
    fixed = code;
    // With even overall parity a nonzero syndrome is a double error: leave data as received.
    if (par && (syn != '0))
      for (int j = 0; j < N; j++)
        if (syn == R'(j + 1)) fixed[j] = ~code[j];
    err = ERR_NONE;
    if (par)             err = ERR_CORR;
    else if (syn != '0)  err = ERR_UNCORR;
  end

  for (genvar k = 0; k < K; k++) begin : g_data
    assign data[k] = fixed[data_pos(R, k)];
  end

endmodule

// File: rtl/core_db_secded.sv
// SECDED data-bucket core: decode {P0,code,IP} packets and queue {data,IP,err} in a FIFO.
// Optional error counters enabled by `define CORE_DB_SECDED_STATS_EN.
module core_db_secded
  import core_db_pkg::*;
#(
  parameter int R     = 3,
  parameter int IP_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [code_w(R)+IP_W:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [data_w(R)+IP_W-1:0]     out_data,
  output logic [1:0]                    out_err
`ifdef CORE_DB_SECDED_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [CNT_W-1:0]              corr_cnt,
  output logic [CNT_W-1:0]              uncorr_cnt
`endif
);

  localparam int N  = code_w(R);
  localparam int K  = data_w(R);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = K + IP_W;

  logic [K-1:0] dec_data;
  err_t         dec_err;

  secded_dec #(.R(R)) u_dec (
    .code (in_data[IP_W +: N]),
    .p0   (in_data[N + IP_W]),
    .data (dec_data),
    .err  (dec_err)
  );

  logic [EW-1:0] mem_data [DEPTH];
  err_t          mem_err  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Head is masked when empty so outputs read zero after reset.
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_err   = out_valid ? mem_err[rd_ptr]  : ERR_NONE;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= {dec_data, in_data[IP_W-1:0]};
      mem_err[wr_ptr]  <= dec_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef CORE_DB_SECDED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n || stat_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (push) begin
      if (dec_err == ERR_CORR && corr_cnt != '1)     corr_cnt   <= corr_cnt + 1'b1;
      if (dec_err == ERR_UNCORR && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_core_db_secded.sv
// Randomized + directed bench for core_db_secded against a queue-based reference model.
module tb_core_db_secded;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_err;
`ifdef CORE_DB_SECDED_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] corr_cnt, uncorr_cnt;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_corr = 0;
  int   m_uncorr = 0;
  exp_t q[$];

  core_db_secded #(.R(3), .IP_W(4), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef CORE_DB_SECDED_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Hamming encoder: returns {P0, code[6:0]} for 4 data bits.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [6:0] c;
    logic       x;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int i = 0; i < 3; i++) begin
      x = 1'b0;
      for (int j = 0; j < 7; j++)
        if ((((j + 1) & (1 << i)) != 0) && ((j + 1) != (1 << i))) x ^= c[j];
      c[(1 << i) - 1] = x;
    end
    return {^c, c};
  endfunction

  // Random packet with 0, 1 or 2 flipped bits; expectation follows from the flip count.
  task automatic make_pkt(output logic [11:0] pkt, output exp_t e);
    logic [3:0] d, ip, dx;
    logic [7:0] cw;
    int nf, b1, b2;
    d  = 4'($urandom);
    ip = 4'($urandom);
    nf = $urandom_range(0, 2);
    cw = encode(d);
    b1 = $urandom_range(0, 7);
    b2 = (b1 + $urandom_range(1, 7)) % 8;
    if (nf >= 1) cw[b1] = ~cw[b1];
    if (nf == 2) cw[b2] = ~cw[b2];
    dx  = (nf == 2) ? {cw[6], cw[5], cw[4], cw[2]} : d;
    pkt = {cw, ip};
    e.d = {dx, ip};
    e.e = (nf == 0) ? 2'b00 : (nf == 1) ? 2'b01 : 2'b10;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    m_corr = 0; m_uncorr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (out_err !== 2'b00) begin n_bad++; $display("FAIL reset_out_err: got %b want 00", out_err); end
`ifdef CORE_DB_SECDED_STATS_EN
    n_cmp++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_decode_cases();
    logic [11:0] vin  [4] = '{12'h555, 12'h455, 12'h445, 12'hD55};
    logic [7:0]  vdat [4] = '{8'hB5,   8'hB5,   8'h95,   8'hB5};
    logic [1:0]  verr [4] = '{2'b00,   2'b01,   2'b10,   2'b01};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = vin[i]; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dec%0d_latency: out_valid %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== vdat[i]) begin n_bad++; $display("FAIL dec%0d_data: got %h want %h", i, out_data, vdat[i]); end
      n_cmp++; if (out_err !== verr[i]) begin n_bad++; $display("FAIL dec%0d_err: got %b want %b", i, out_err, verr[i]); end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dec%0d_drain: out_valid %b want 0", i, out_valid); end
    end
`ifdef CORE_DB_SECDED_STATS_EN
    n_cmp++; if (corr_cnt !== 16'd2 || uncorr_cnt !== 16'd1) begin
      n_bad++; $display("FAIL dec_cnt: got %0d/%0d want 2/1", corr_cnt, uncorr_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    logic [11:0] pk [6];
    logic [7:0]  ex [6];
    for (int i = 0; i < 6; i++) begin
      pk[i] = {encode(4'(i + 1)), 4'(i + 8)};
      ex[i] = {4'(i + 1), 4'(i + 8)};
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = pk[i]; out_ready = 1'b0;
      n_cmp++; if (in_ready !== (i < 4)) begin n_bad++; $display("FAIL bp_in_ready%0d: got %b want %b", i, in_ready, (i < 4)); end
      @(posedge clk);
    end
    @(negedge clk);
    in_data = pk[5]; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== ex[0]) begin n_bad++; $display("FAIL bp_head0: got %h want %h", out_data, ex[0]); end
    @(posedge clk);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== ex[i]) begin
        n_bad++; $display("FAIL bp_order%0d: got v%b %h want v1 %h", i, out_valid, out_data, ex[i]); end
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_extra_push: out_valid %b want 0 (data %h)", out_valid, out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] pkt;
    exp_t        e;
    logic        push_m, pop_m;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== (q.size() < DEPTH)) begin
        n_bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, (q.size() < DEPTH)); end
      n_cmp++; if (out_valid !== (q.size() != 0)) begin
        n_bad++; $display("FAIL rnd_out_valid@%0d: got %b want %b", c, out_valid, (q.size() != 0)); end
      if (q.size() != 0) begin
        n_cmp++; if (out_data !== q[0].d || out_err !== q[0].e) begin
          n_bad++; $display("FAIL rnd_head@%0d: got %h/%b want %h/%b", c, out_data, out_err, q[0].d, q[0].e); end
      end
      make_pkt(pkt, e);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = pkt;
      out_ready = ($urandom_range(0, 2) != 0);
      push_m = in_valid && (q.size() < DEPTH);
      pop_m  = out_ready && (q.size() != 0);
      @(posedge clk);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(e);
        if (e.e == 2'b01) m_corr++;
        if (e.e == 2'b10) m_uncorr++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
`ifdef CORE_DB_SECDED_STATS_EN
    n_cmp++; if (corr_cnt !== 16'(m_corr) || uncorr_cnt !== 16'(m_uncorr)) begin
      n_bad++; $display("FAIL rnd_cnt: got %0d/%0d want %0d/%0d", corr_cnt, uncorr_cnt, m_corr, m_uncorr); end
    in_valid = 1'b1; in_data = 12'h455; out_ready = 1'b1; stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0; in_valid = 1'b0;
    n_cmp++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      n_bad++; $display("FAIL clr_priority: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
`endif
  endtask

  task automatic test_reset_midstream();
    logic [11:0] pk;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 12'h455 ^ 12'(i); out_ready = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
`ifdef CORE_DB_SECDED_STATS_EN
    n_cmp++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      n_bad++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end
`endif
    pk = {encode(4'hC), 4'h3};
    in_valid = 1'b1; in_data = pk;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_err !== 2'b00) begin
      n_bad++; $display("FAIL mid_latency: got v%b %h/%b want v1 c3/00", out_valid, out_data, out_err); end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode_cases();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_db_secded.md
Name: core_db_secded

Overview:
- Parametrised successor to the Hamming(7,4) data-bucket core.
- Accepts {SECDED codeword, IP} packets from the router on a valid/ready channel.
- Decodes the codeword with single-error correction and double-error detection, then strips the check bits.
- Queues {data, IP} plus an error code in an output FIFO toward the data bucket.

Parameters:
- R, 3, Hamming check bits; N = 2^R-1 code bits, K = N-R data bits (default N=7, K=4).
- IP_W, 4, IP field width.
- DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  input packet valid.
- in_ready  out  1  block can accept a packet.
- in_data  in  N+1+IP_W  packet layout |P0|code[N-1:0]|IP[IP_W-1:0]|. code[j] is Hamming position j+1. P0 is even parity over code and P0.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  K+IP_W  output layout |data[K-1:0]|IP|.
- out_err  out  2  error code: 00 clean, 01 corrected, 10 uncorrectable.
- stat_clr  in  1  clears counters (present only with the optional feature).
- corr_cnt  out  16  corrected-packet count (optional feature only).
- uncorr_cnt  out  16  uncorrectable-packet count (optional feature only).

Behaviour:
- Reset (reset_n low at a clk edge):
  - FIFO empty; pointers and count 0.
  - out_valid=0, out_data=0, out_err=0, in_ready=1.
  - Counters 0.
  - Reset overrides any simultaneous push or pop; an entry in flight is discarded.
- Decode is combinational on in_data:
  - Syndrome s[R-1:0]: s[i] is the XOR of code[j] over all j where bit i of (j+1) is set.
  - p is the XOR of all N+1 code and P0 bits.
- Decode cases:
  - s=0, p=0: clean, err=00.
  - s!=0, p=1: flip code[s-1], err=01.
  - s=0, p=1: P0 itself is in error; data clean, err=01.
  - s!=0, p=0: double error; data passed uncorrected, err=10.
- Data extraction: data bits are taken from the non-power-of-two positions in ascending order, with data[0] at position 3. For R=3, data = {code[6], code[5], code[4], code[2]}.
- Handshake:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH). There is no full-bypass: when full, no push occurs even if a pop happens in the same cycle.
  - out_valid = (count != 0).
  - out_data and out_err are driven from the FIFO head.
  - Latency: a packet accepted at edge t is visible on out_* after edge t (1 cycle) when the FIFO was empty.
- Pointers: wrap modulo DEPTH. Simultaneous push and pop when not full and not empty leaves count unchanged.
- Stalls: while out_valid is high and out_ready is low, out_data and out_err stay stable.
- Ordering: strictly FIFO; there is no reordering between IPs.

Optional Feature:
- Macro: CORE_DB_SECDED_STATS_EN.
- When defined:
  - corr_cnt and uncorr_cnt increment on the push of an err=01 or err=10 entry respectively.
  - Both are 16-bit and saturate at 16'hFFFF.
  - stat_clr high at an edge zeroes both and takes priority over an increment in the same cycle.
- When undefined: stat_clr, corr_cnt and uncorr_cnt ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package core_db_pkg holds:
  - function widths: code_w(R), data_w(R);
  - typedef err_t with enum ERR_NONE=2'b00, ERR_CORR=2'b01, ERR_UNCORR=2'b10;
  - constant CNT_W=16.
- One sub-module, secded_dec: combinational, parametrised by R. Takes code and P0; returns data and err.
- The FIFO stays inline in core_db_secded.

Test Plan:
- Clean packet: data 4'b1011, IP 4'h5, in_data=12'h555 -> out_data=8'hB5, err=00, out_valid 1 cycle after accept.
- Single error: in_data=12'h455 (code[4] flipped) -> out_data=8'hB5, err=01; corr_cnt=1 with the feature enabled.
- Double error: in_data=12'h445 (code[4] and code[0] flipped) -> out_data=8'h95, err=10; uncorr_cnt increments.
- P0 error: in_data=12'hD55 -> out_data=8'hB5, err=01.
- Backpressure: hold out_ready=0 and push 5 packets -> in_ready drops after the 4th; then pop -> 4 entries emerge in order, and a full plus simultaneous-pop cycle does not push.
- Reset mid-stream with 3 entries queued and reset_n low for 1 cycle -> out_valid=0, in_ready=1, counters 0; the next packet has 1-cycle latency.
